// File: rtl/nec_ir_tx_if.sv
// Request/status bundle between a command source and the NEC IR transmitter.
interface nec_ir_tx_if;
  logic        send;
  logic [15:0] addr;
  logic [7:0]  cmd;
  logic        ext_addr;
  logic        repeat_en;
  logic        busy;
  logic        frame_done;
  logic        env_out;
  logic        data_out;
  logic [3:0]  tx_state;

  modport master (
    output send, addr, cmd, ext_addr, repeat_en,
    input  busy, frame_done, env_out, data_out, tx_state
  );

  modport slave (
    input  send, addr, cmd, ext_addr, repeat_en,
    output busy, frame_done, env_out, data_out, tx_state
  );
endinterface

// File: rtl/nec_ir_tx.sv
// NEC infrared frame transmitter: leader, 32 data bits LSB first, stop mark,
// fixed-period gap and optional repeat codes, with a gated carrier output.
module nec_ir_tx #(
  parameter int CLK_HZ       = 50000000,
  parameter int CARRIER_HZ   = 38000,
  parameter int DUTY_PCT     = 33,
  parameter int PERIOD_UNITS = 192
) (
  input  logic       clk,
  input  logic       rst_n,
  nec_ir_tx_if.slave bus
);

  localparam int UNIT_CLKS  = CLK_HZ * 9 / 16000;
  localparam int CAR_PERIOD = CLK_HZ / CARRIER_HZ;
  localparam int CAR_HIGH   = CAR_PERIOD * DUTY_PCT / 100;
  localparam int UW = (UNIT_CLKS > 1) ? $clog2(UNIT_CLKS) : 1;
  localparam int CW = (CAR_PERIOD > 1) ? $clog2(CAR_PERIOD) : 1;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_LEAD_MARK  = 4'd1,
    S_LEAD_SPACE = 4'd2,
    S_BIT_MARK   = 4'd3,
    S_BIT_SPACE  = 4'd4,
    S_STOP_MARK  = 4'd5,
    S_GAP        = 4'd6,
    S_REP_MARK   = 4'd7,
    S_REP_SPACE  = 4'd8,
    S_REP_STOP   = 4'd9
  } state_t;

  state_t          state, state_d;
  logic [UW-1:0]   clk_cnt;
  logic [4:0]      unit_cnt;
  logic [4:0]      unit_last;
  logic [15:0]     period_cnt;
  logic [4:0]      bit_idx;
  logic [31:0]     data_sr;
  logic            rep_q;
  logic [CW-1:0]   car_cnt, car_d;
  logic            busy_q, done_q, env_q, data_q;
  logic            unit_tick, unit_done, period_end;

  function automatic logic is_mark(input state_t s);
    return (s == S_LEAD_MARK) || (s == S_BIT_MARK) || (s == S_STOP_MARK) ||
           (s == S_REP_MARK)  || (s == S_REP_STOP);
  endfunction

  assign unit_tick  = (state != S_IDLE) && (clk_cnt == UW'(UNIT_CLKS - 1));
  assign unit_done  = unit_tick && (unit_cnt == unit_last);
  assign period_end = (state == S_GAP) && unit_tick &&
                      (period_cnt >= 16'(PERIOD_UNITS - 1));

  // Duration of the current state in units, minus one.
  always_comb begin
    unit_last = 5'd0;
    case (state)
      S_LEAD_MARK, S_REP_MARK: unit_last = 5'd15;
      S_LEAD_SPACE:            unit_last = 5'd7;
      S_BIT_SPACE:             unit_last = data_sr[0] ? 5'd2 : 5'd0;
      S_REP_SPACE:             unit_last = 5'd3;
      default:                 unit_last = 5'd0;
    endcase
  end

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state;
    case (state)
      S_IDLE:       if (bus.send)  state_d = S_LEAD_MARK;
      S_LEAD_MARK:  if (unit_done) state_d = S_LEAD_SPACE;
      S_LEAD_SPACE: if (unit_done) state_d = S_BIT_MARK;
      S_BIT_MARK:   if (unit_done) state_d = S_BIT_SPACE;
      S_BIT_SPACE:  if (unit_done) state_d = (bit_idx == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
      S_STOP_MARK:  if (unit_done) state_d = S_GAP;
      S_GAP:        if (period_end) state_d = (rep_q && bus.send) ? S_REP_MARK : S_IDLE;
      S_REP_MARK:   if (unit_done) state_d = S_REP_SPACE;
      S_REP_SPACE:  if (unit_done) state_d = S_REP_STOP;
      S_REP_STOP:   if (unit_done) state_d = S_GAP;
      default:      state_d = S_IDLE;
    endcase
  end

  // Carrier phase restarts on every state change so each mark opens high.
  always_comb begin
    car_d = '0;
    if (state_d == state)
      car_d = (car_cnt == CW'(CAR_PERIOD - 1)) ? '0 : car_cnt + CW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      clk_cnt    <= '0;
      unit_cnt   <= '0;
      period_cnt <= '0;
      bit_idx    <= '0;
      // NOTE: the latched frame is cleared too so an aborted frame leaves nothing behind.
      data_sr    <= '0;
      rep_q      <= 1'b0;
      car_cnt    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      env_q      <= 1'b0;
      data_q     <= 1'b0;
    end else begin
      state   <= state_d;
      car_cnt <= car_d;
      busy_q  <= (state_d != S_IDLE);
      done_q  <= period_end;
      env_q   <= is_mark(state_d);
      data_q  <= is_mark(state_d) && (car_d < CW'(CAR_HIGH));

      if (state == S_IDLE || unit_tick) clk_cnt <= '0;
      else                              clk_cnt <= clk_cnt + UW'(1);

      if (state_d != state) unit_cnt <= '0;
      else if (unit_tick)   unit_cnt <= unit_cnt + 5'd1;

      if (state_d != state && (state_d == S_LEAD_MARK || state_d == S_REP_MARK))
        period_cnt <= '0;
      else if (unit_tick)
        period_cnt <= period_cnt + 16'd1;

      if (state == S_IDLE && bus.send) begin
        data_sr <= {~bus.cmd, bus.cmd,
                    bus.ext_addr ? bus.addr[15:8] : ~bus.addr[7:0],
                    bus.addr[7:0]};
        rep_q   <= bus.repeat_en;
        bit_idx <= '0;
      end else if (state == S_BIT_SPACE && unit_done) begin
        data_sr <= data_sr >> 1;
        bit_idx <= bit_idx + 5'd1;
      end
    end
  end

  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;
  assign bus.env_out    = env_q;
  assign bus.data_out   = data_q;
  assign bus.tx_state   = state;

endmodule

// File: tb/tb_nec_ir_tx.sv
// Directed bench for nec_ir_tx: an envelope decoder pops expected frames and
// repeat codes from a scoreboard queue filled when each request is driven.
module tb_nec_ir_tx;

  localparam int UNIT   = 18;
  localparam int PERIOD = 192 * UNIT;
  localparam logic [3:0] ST_IDLE = 4'd0, ST_LEAD = 4'd1, ST_BIT_SPACE = 4'd4,
                         ST_REP_MARK = 4'd7;

  typedef struct packed {
    logic        rep;
    logic [31:0] word;
  } exp_t;

  typedef enum {PH_HDR, PH_BITS, PH_REP} phase_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  nec_ir_tx_if bus();

  nec_ir_tx #(
    .CLK_HZ      (32000),
    .CARRIER_HZ  (4000),
    .DUTY_PCT    (50),
    .PERIOD_UNITS(192)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Envelope decoder state
  phase_t      phase = PH_HDR;
  logic        prev_env = 1'b0;
  logic        cur_env;
  logic        timing_ok = 1'b0;
  logic [31:0] word = '0;
  int          run_len = 0, mark_len = 0, nbits = 0, pos = 0;
  int          carrier_bad = 0, last_fall = 0;

  task automatic finish_msg(input logic rep, input logic [31:0] w);
    exp_t e;
    check("exp_available", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("msg_kind", 32'(rep), 32'(e.rep));
      if (!rep) check("frame_word", w, e.word);
    end
    check("msg_timing", 32'(timing_ok), 32'd1);
    check("carrier", 32'(carrier_bad), 32'd0);
    carrier_bad = 0;
    phase = PH_HDR;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      phase       = PH_HDR;
      prev_env    = 1'b0;
      run_len     = 0;
      carrier_bad = 0;
    end else begin
      cur_env = bus.env_out;
      pos = (cur_env == prev_env) ? run_len : 0;
      if (cur_env) begin
        if (bus.data_out !== ((pos % 8) < 4)) carrier_bad++;
      end else if (bus.data_out !== 1'b0) begin
        carrier_bad++;
      end
      if (cur_env == prev_env) begin
        run_len++;
      end else begin
        if (prev_env) begin
          mark_len  = run_len;
          last_fall = cyc;
          if (phase == PH_BITS && nbits == 32) begin
            timing_ok &= (mark_len == UNIT);
            finish_msg(1'b0, word);
          end else if (phase == PH_REP) begin
            timing_ok &= (mark_len == UNIT);
            finish_msg(1'b1, 32'd0);
          end
        end else begin
          case (phase)
            PH_HDR: begin
              if (mark_len == 16 * UNIT && run_len == 8 * UNIT) begin
                phase = PH_BITS; nbits = 0; timing_ok = 1'b1;
              end else if (mark_len == 16 * UNIT && run_len == 4 * UNIT) begin
                phase = PH_REP; timing_ok = 1'b1;
              end
            end
            PH_BITS: begin
              timing_ok &= (mark_len == UNIT);
              if (run_len == 3 * UNIT) word = {1'b1, word[31:1]};
              else begin
                word = {1'b0, word[31:1]};
                if (run_len != UNIT) timing_ok = 1'b0;
              end
              nbits++;
            end
            default: ;
          endcase
        end
        run_len = 1;
      end
      prev_env = cur_env;
    end
  end

  task automatic start_frame(input logic [15:0] a, input logic [7:0] c, input logic e,
                             input logic r, input logic hold, output int c0);
    @(negedge clk);
    bus.addr = a; bus.cmd = c; bus.ext_addr = e; bus.repeat_en = r; bus.send = 1'b1;
    @(negedge clk);
    if (!hold) bus.send = 1'b0;
    c0 = cyc;
    check("lead_start", 32'({bus.busy, bus.tx_state, bus.env_out, bus.data_out}),
          32'({1'b1, ST_LEAD, 1'b1, 1'b1}));
  endtask

  task automatic wait_frame_done(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.frame_done && n < PERIOD + 500);
    check(tag, 32'(bus.frame_done), 32'd1);
  endtask

  initial begin
    int c0, c1, c2, n;
    bus.send = 1'b0; bus.addr = '0; bus.cmd = '0; bus.ext_addr = 1'b0; bus.repeat_en = 1'b0;
    #1;
    check("reset_outputs", 32'({bus.busy, bus.frame_done, bus.env_out, bus.data_out, bus.tx_state}), 32'd0);
    #20;
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_reset", 32'({bus.busy, bus.tx_state}), 32'd0);

    // Standard address frame
    exp_q.push_back('{rep: 1'b0, word: 32'hED127986});
    start_frame(16'h0086, 8'h12, 1'b0, 1'b0, 1'b0, c0);
    wait_frame_done("t1_done_seen");
    check("t1_period", 32'(cyc - c0), 32'(PERIOD));
    check("t1_busy_at_done", 32'(bus.busy), 32'd0);
    check("t1_marks_end", 32'(last_fall - c0), 32'(121 * UNIT));
    check("t1_state_idle", 32'(bus.tx_state), 32'(ST_IDLE));

    // Extended address frame
    exp_q.push_back('{rep: 1'b0, word: 32'hFF00A55A});
    start_frame(16'hA55A, 8'h00, 1'b1, 1'b0, 1'b0, c0);
    wait_frame_done("t2_done_seen");
    check("t2_period", 32'(cyc - c0), 32'(PERIOD));

    // New requests while busy must not disturb the frame in flight
    exp_q.push_back('{rep: 1'b0, word: 32'hC33C1234});
    start_frame(16'h1234, 8'h3C, 1'b1, 1'b0, 1'b0, c0);
    for (int i = 0; i < 5; i++) begin
      repeat (200) @(negedge clk);
      bus.addr = 16'hFFFF; bus.cmd = 8'h99; bus.ext_addr = 1'b0; bus.send = 1'b1;
      @(negedge clk);
      bus.send = 1'b0;
    end
    check("t3_busy_held", 32'(bus.busy), 32'd1);
    wait_frame_done("t3_done_seen");
    check("t3_period", 32'(cyc - c0), 32'(PERIOD));
    repeat (20) @(negedge clk);
    check("t3_stays_idle", 32'({bus.busy, bus.tx_state}), 32'd0);

    // Held send with repeats; send dropped during the second repeat
    exp_q.push_back('{rep: 1'b0, word: 32'h5FA001FE});
    exp_q.push_back('{rep: 1'b1, word: 32'h0});
    exp_q.push_back('{rep: 1'b1, word: 32'h0});
    start_frame(16'h00FE, 8'hA0, 1'b0, 1'b1, 1'b1, c0);
    wait_frame_done("t4_done1_seen");
    check("t4_period1", 32'(cyc - c0), 32'(PERIOD));
    check("t4_rep1_start", 32'({bus.busy, bus.env_out, bus.tx_state}), 32'({1'b1, 1'b1, ST_REP_MARK}));
    c1 = cyc;
    wait_frame_done("t4_done2_seen");
    check("t4_period2", 32'(cyc - c1), 32'(PERIOD));
    check("t4_rep2_start", 32'(bus.tx_state), 32'(ST_REP_MARK));
    c2 = cyc;
    repeat (100) @(negedge clk);
    bus.send = 1'b0;
    wait_frame_done("t4_done3_seen");
    check("t4_period3", 32'(cyc - c2), 32'(PERIOD));
    check("t4_idle_after", 32'({bus.busy, bus.tx_state}), 32'd0);

    // Asynchronous reset in the middle of the data bits
    start_frame(16'h00C3, 8'h81, 1'b0, 1'b0, 1'b0, c0);
    n = 0;
    while (bus.tx_state != ST_BIT_SPACE && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("t5_in_bit_space", 32'(bus.tx_state), 32'(ST_BIT_SPACE));
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_clear", 32'({bus.busy, bus.frame_done, bus.env_out, bus.data_out, bus.tx_state}), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (50) @(negedge clk);
    check("t5_no_self_start", 32'({bus.busy, bus.tx_state}), 32'd0);
    exp_q.push_back('{rep: 1'b0, word: 32'hF00FAA55});
    start_frame(16'h0055, 8'h0F, 1'b0, 1'b0, 1'b0, c0);
    wait_frame_done("t5_done_seen");
    check("t5_period", 32'(cyc - c0), 32'(PERIOD));

    repeat (10) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nec_ir_tx.md
NEC_IR_TX -- requirements
Module: nec_ir_tx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 SHALL have parameter CARRIER_HZ, default 38000, IR carrier frequency in Hz.
REQ-003 SHALL have parameter DUTY_PCT, default 33, carrier high-time percentage (1..99).
REQ-004 SHALL have parameter PERIOD_UNITS, default 192, frame repetition period in units; unit = 562.5 us = CLK_HZ*9/16000 clocks (UNIT_CLKS, integer-truncated).
REQ-005 SHALL have port clk, input, 1, single clock; all state on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-007 SHALL have port send, input, 1, transmit request level; held high requests repeat codes.
REQ-008 SHALL have port addr, input, 16, address; only [7:0] used when ext_addr=0.
REQ-009 SHALL have port cmd, input, 8, command byte.
REQ-010 SHALL have port ext_addr, input, 1, 1 = 16-bit extended address mode.
REQ-011 SHALL have port repeat_en, input, 1, enables repeat-code generation.
REQ-012 SHALL have port busy, output, 1, high from acceptance until the period ends.
REQ-013 SHALL have port frame_done, output, 1, one-clock pulse at each period end.
REQ-014 SHALL have port env_out, output, 1, unmodulated mark envelope (1 = mark).
REQ-015 SHALL have port data_out, output, 1, env_out AND carrier, to IR LED.
REQ-016 SHALL have port tx_state, output, 4, current state encoding, for LEDs/debug.

Function
REQ-017 SHALL accept a request when state is IDLE and send=1; addr, cmd, ext_addr and repeat_en latch on that edge; busy rises on the next cycle; send while busy=1 is ignored for new data.
REQ-018 SHALL sequence states IDLE -> LEAD_MARK (16 units) -> LEAD_SPACE (8) -> BIT_MARK (1) -> BIT_SPACE (1 for 0, 3 for 1), x32 -> STOP_MARK (1) -> GAP -> IDLE or REP_MARK.
REQ-019 SHALL transmit 32 bits LSB first: byte0 = addr[7:0]; byte1 = addr[15:8] if ext_addr else ~addr[7:0]; byte2 = cmd; byte3 = ~cmd.
REQ-020 SHALL count units with a period counter cleared at LEAD_MARK/REP_MARK entry; GAP lasts until counter reaches PERIOD_UNITS, then frame_done pulses for one cycle.
REQ-021 SHALL, at period end, go to REP_MARK (16) -> REP_SPACE (4) -> REP_STOP (1) -> GAP if latched repeat_en=1 and send=1; otherwise IDLE with busy=0 in the same cycle as frame_done.
REQ-022 SHALL sample send for repeats only at the period-end cycle; a drop mid-period does not truncate the current frame or repeat.
REQ-023 SHALL generate carrier with period CLK_HZ/CARRIER_HZ clocks, high for first period*DUTY_PCT/100 clocks; carrier counter restarts at every mark entry so each mark begins high.
REQ-024 SHALL drive env_out=1 only in LEAD_MARK, BIT_MARK, STOP_MARK, REP_MARK, REP_STOP; data_out=0 whenever env_out=0.
REQ-025 SHALL transition on the last clock of each unit count, with no extra idle cycles between states.

Reset
REQ-026 SHALL on rst_n=0 immediately force state IDLE, busy=0, frame_done=0, env_out=0, data_out=0, tx_state=0, and clear all counters and latched data, including mid-frame.
REQ-027 SHALL after rst_n release require a fresh send=1 sample in IDLE to start.

Verification (sim params CLK_HZ=32000, CARRIER_HZ=4000, DUTY_PCT=50: UNIT_CLKS=18, carrier 8 clk, 4 high)
REQ-028 SHALL verify: addr=0x0086, cmd=0x12, ext_addr=0, 1-cycle send -> bits 86,79,12,ED LSB first; env_out high 288 clk, low 144, frame marks end at unit 121; frame_done at unit 192; busy low after.
REQ-029 SHALL verify: ext_addr=1, addr=0xA55A, cmd=0x00 -> byte0=0x5A, byte1=0xA5, byte3=0xFF.
REQ-030 SHALL verify: send held, repeat_en=1 -> after frame, repeat marks 16/4/1 units at each 192-unit boundary; send dropped mid-repeat -> that repeat completes, then IDLE.
REQ-031 SHALL verify: carrier on data_out during any mark = 4 high / 4 low clocks, first clock of each mark high.
REQ-032 SHALL verify: rst_n pulsed low in BIT_SPACE -> all outputs 0 asynchronously; new send afterwards restarts with LEAD_MARK.
REQ-033 SHALL verify: send pulses while busy=1 with different addr -> ignored; transmitted data equals first latched values.
